// File: rtl/conv_layer_pkg.sv
// Shared types and helpers for the convolution-layer batch scheduler.
// EXT_ADDR_WIDTH comes from the global define set; a 16-bit fallback keeps
// standalone builds working.
`ifndef EXT_ADDR_WIDTH
`define EXT_ADDR_WIDTH 16
`endif

package conv_layer_pkg;

  localparam int EXT_ADDR_WIDTH = `EXT_ADDR_WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    GAP,
    WAIT_RDY,
    RUN,
    CHECK,
    DONE,
    ERR
  } sched_state_t;

  // Number of bits needed to hold values 0..value-1 (ceil(log2(value))).
  function automatic int logb2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Feature rows expected from the layer for one image.
  function automatic int rows_per_image(input int array_size, input int total_weight);
    return array_size * total_weight;
  endfunction

endpackage

// File: rtl/conv_sched_edge_counter.sv
// Rising-edge detector on the layer's valid strobe feeding a saturating row
// counter. The counter saturates one above the expected row count so that an
// overrun can never wrap back onto the expected value.
module conv_sched_edge_counter #(
  parameter int SAT_VALUE = 25,
  parameter int CNT_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 en,
  input  logic                 valid,
  output logic                 rise,
  output logic [CNT_WIDTH-1:0] count
);

  localparam logic [CNT_WIDTH-1:0] SAT = CNT_WIDTH'(SAT_VALUE);

  logic valid_q;

  assign rise = valid & ~valid_q;

  // Track previous valid and count rising edges while enabled, up to SAT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      count   <= '0;
    end else begin
      valid_q <= valid;
      if (clr) begin
        count <= '0;
      end else if (en && rise && (count != SAT)) begin
        count <= count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/conv_layer_batch_scheduler.sv
// Batch sequencer for conv_layer_top: gates the layer enable, offsets its ROM
// address by a per-image base and checks the row count of every image.
// Optional feature macro: CONV_SCHED_WATCHDOG_EN (RUN-state stall watchdog).
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for start
// WAIT_RDY | enable low, waiting for downstream out_ready
// RUN      | enable high, counting valid edges until image_calc_fin
// CHECK    | one cycle, compare row count, pick next image / done / error
// GAP      | enable low for GAP_CYCLES so the layer sees a restart edge
// DONE     | one-cycle done pulse
// ERR      | sticky error, waits for a new start
module conv_layer_batch_scheduler
  import conv_layer_pkg::*;
#(
  parameter int ARRAY_SIZE   = 6,
  parameter int TOTAL_WEIGHT = 4,
  parameter int IMAGE_STRIDE = 64,
  parameter int MAX_IMAGES   = 16,
  parameter int GAP_CYCLES   = 2,
  parameter int WDOG_CYCLES  = 4096,
  parameter int IMG_WIDTH    = logb2(MAX_IMAGES) + 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [IMG_WIDTH-1:0]      num_images,
  input  logic                      out_ready,
  input  logic                      conv_valid,
  input  logic                      conv_image_calc_fin,
  input  logic [EXT_ADDR_WIDTH-1:0] conv_ext_rom_addr,
  output logic                      conv_enable,
  output logic [EXT_ADDR_WIDTH-1:0] ext_rom_addr,
  output logic [IMG_WIDTH-1:0]      image_idx,
  output logic                      busy,
  output logic                      done,
  output logic                      error
);

  localparam int ROWS_PER_IMAGE = rows_per_image(ARRAY_SIZE, TOTAL_WEIGHT);
  localparam int CNT_W = logb2(ROWS_PER_IMAGE + 2);
  localparam int GAP_W = (GAP_CYCLES > 2) ? logb2(GAP_CYCLES) : 1;

  localparam logic [CNT_W-1:0]          ROWS_CNT   = CNT_W'(ROWS_PER_IMAGE);
  localparam logic [EXT_ADDR_WIDTH-1:0] STRIDE     = EXT_ADDR_WIDTH'(IMAGE_STRIDE);
  localparam logic [GAP_W-1:0]          GAP_RELOAD = GAP_W'(GAP_CYCLES - 1);

  sched_state_t              state;
  logic [EXT_ADDR_WIDTH-1:0] base;
  logic [IMG_WIDTH-1:0]      last_idx;
  logic [GAP_W-1:0]          gap_cnt;
  logic [CNT_W-1:0]          row_cnt;
  logic                      rise;
  logic                      cnt_clr;
  logic                      cnt_en;
  logic                      wdog_expired;

  assign ext_rom_addr = base + conv_ext_rom_addr;
  assign cnt_clr      = (state == WAIT_RDY) && out_ready;
  assign cnt_en       = (state == RUN);

  conv_sched_edge_counter #(
    .SAT_VALUE (ROWS_PER_IMAGE + 1),
    .CNT_WIDTH (CNT_W)
  ) u_edge_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .valid (conv_valid),
    .rise  (rise),
    .count (row_cnt)
  );

`ifdef CONV_SCHED_WATCHDOG_EN
  localparam int WDOG_W = (WDOG_CYCLES > 2) ? logb2(WDOG_CYCLES) : 1;
  localparam logic [WDOG_W-1:0] WDOG_RELOAD = WDOG_W'(WDOG_CYCLES - 1);

  logic [WDOG_W-1:0] wdog_cnt;

  // Down-counter reloaded outside RUN and on every valid edge inside RUN.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wdog_cnt <= WDOG_RELOAD;
    end else if ((state != RUN) || rise) begin
      wdog_cnt <= WDOG_RELOAD;
    end else if (wdog_cnt != '0) begin
      wdog_cnt <= wdog_cnt - WDOG_W'(1);
    end
  end

  assign wdog_expired = (state == RUN) && !rise && (wdog_cnt == '0);
`else
  // Watchdog compiled out: the term is constant zero for any legal
  // WDOG_CYCLES, so RUN waits for image_calc_fin indefinitely.
  assign wdog_expired = rise & (WDOG_CYCLES < 0);
`endif

  // Batch sequencing FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      conv_enable <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      image_idx   <= '0;
      base        <= '0;
      last_idx    <= '0;
      gap_cnt     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, ERR: begin
          if (start) begin
            last_idx    <= (num_images == '0) ? '0 : num_images - IMG_WIDTH'(1);
            image_idx   <= '0;
            base        <= '0;
            error       <= 1'b0;
            busy        <= 1'b1;
            conv_enable <= 1'b0;
            state       <= WAIT_RDY;
          end
        end
        WAIT_RDY: begin
          if (out_ready) begin
            conv_enable <= 1'b1;
            state       <= RUN;
          end
        end
        RUN: begin
          if (conv_image_calc_fin) begin
            conv_enable <= 1'b0;
            state       <= CHECK;
          end else if (wdog_expired) begin
            conv_enable <= 1'b0;
            busy        <= 1'b0;
            error       <= 1'b1;
            state       <= ERR;
          end
        end
        CHECK: begin
          if (row_cnt != ROWS_CNT) begin
            busy  <= 1'b0;
            error <= 1'b1;
            state <= ERR;
          end else if (image_idx == last_idx) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            image_idx <= image_idx + IMG_WIDTH'(1);
            base      <= base + STRIDE;
            gap_cnt   <= GAP_RELOAD;
            state     <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            state <= WAIT_RDY;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          conv_enable <= 1'b0;
          busy        <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_layer_batch_scheduler.sv
// Self-checking bench for conv_layer_batch_scheduler: table of batch
// scenarios plus randomized batches, each driven cycle by cycle with
// expectations derived from the batch rules (base = idx*stride, row count
// must equal rows per image, fixed latencies between phases).
module tb_conv_layer_batch_scheduler;
  import conv_layer_pkg::*;

  localparam int ROWS   = 24;
  localparam int GAPC   = 2;
  localparam int STRIDE = 64;
  localparam int WDOG   = 50;
  localparam int IMG_W  = logb2(16) + 1;
  localparam int AW     = EXT_ADDR_WIDTH;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [IMG_W-1:0] num_images;
  logic             out_ready;
  logic             conv_valid;
  logic             conv_image_calc_fin;
  logic [AW-1:0]    conv_ext_rom_addr;
  logic             conv_enable;
  logic [AW-1:0]    ext_rom_addr;
  logic [IMG_W-1:0] image_idx;
  logic             busy;
  logic             done;
  logic             error;

  int errors = 0;
  int checks = 0;

  conv_layer_batch_scheduler #(
    .ARRAY_SIZE   (6),
    .TOTAL_WEIGHT (4),
    .IMAGE_STRIDE (STRIDE),
    .MAX_IMAGES   (16),
    .GAP_CYCLES   (GAPC),
    .WDOG_CYCLES  (WDOG)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .start               (start),
    .num_images          (num_images),
    .out_ready           (out_ready),
    .conv_valid          (conv_valid),
    .conv_image_calc_fin (conv_image_calc_fin),
    .conv_ext_rom_addr   (conv_ext_rom_addr),
    .conv_enable         (conv_enable),
    .ext_rom_addr        (ext_rom_addr),
    .image_idx           (image_idx),
    .busy                (busy),
    .done                (done),
    .error               (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int num;
    int bad_img;
    int bad_pulses;
    int rdy_delay;
    int coinc;
    int spam;
    int abort_img;
    int stall;
    int exp_done;
    int exp_err;
    int exp_idx;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    chk("done_busy_exclusive", 64'(done & busy), 0);
  endtask

  task automatic run_batch(input vec_t v, output int got_done, output int got_err,
                           output int got_idx);
    int eff, pulses, low_cnt, a, npre;
    got_done = 0;
    got_err  = 0;
    got_idx  = -1;
    low_cnt  = 0;
    eff = (v.num == 0) ? 1 : v.num;
    num_images = IMG_W'(v.num);
    out_ready  = (v.rdy_delay == 0);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int img = 0; img < eff; img++) begin
      chk("wait_enable", conv_enable, 0);
      chk("wait_busy", busy, 1);
      chk("wait_error", error, 0);
      chk("wait_idx", image_idx, img);
      if (!conv_enable) low_cnt++;
      for (int k = 0; k < v.rdy_delay; k++) begin
        step();
        chk("wait_hold", conv_enable, 0);
        if (!conv_enable) low_cnt++;
      end
      out_ready = 1'b1;
      step();
      chk("run_enable", conv_enable, 1);
      if (img > 0) chk("gap_len", low_cnt, 1 + GAPC + 1 + v.rdy_delay);
      a = int'($urandom_range(0, (1 << AW) - 1));
      conv_ext_rom_addr = AW'(a);
      #1;
      chk("rom_addr", ext_rom_addr, 64'((longint'(img) * STRIDE + a) % (longint'(1) << AW)));
      for (int k = 0; k < v.stall; k++) begin
        step();
`ifndef CONV_SCHED_WATCHDOG_EN
        chk("stall_enable", conv_enable, 1);
        chk("stall_busy", busy, 1);
`endif
      end
`ifdef CONV_SCHED_WATCHDOG_EN
      if (v.stall >= WDOG) begin
        chk("wdog_error", error, 1);
        chk("wdog_enable", conv_enable, 0);
        chk("wdog_busy", busy, 0);
        got_err = error;
        got_idx = int'(image_idx);
        return;
      end
`endif
      pulses = (img == v.bad_img) ? v.bad_pulses : ROWS;
      npre = (v.coinc != 0 && pulses > 0) ? pulses - 1 : pulses;
      for (int p = 0; p < npre; p++) begin
        conv_valid = 1'b1;
        step();
        chk("run_hold", conv_enable, 1);
        conv_valid = 1'b0;
        if (v.spam != 0 && p == 3) begin
          start = 1'b1;
          num_images = IMG_W'($urandom_range(1, 15));
        end
        step();
        start = 1'b0;
        chk("run_hold", conv_enable, 1);
        chk("run_busy", busy, 1);
        if ($urandom_range(0, 1) == 1) begin
          step();
          chk("run_hold", conv_enable, 1);
        end
        if (img == v.abort_img && p == 5) begin
          rst_n = 1'b0;
          step();
          chk("rst_enable", conv_enable, 0);
          chk("rst_busy", busy, 0);
          chk("rst_done", done, 0);
          chk("rst_error", error, 0);
          chk("rst_idx", image_idx, 0);
          #1;
          chk("rst_rom_addr", ext_rom_addr, 64'(a));
          rst_n = 1'b1;
          step();
          got_done = done;
          got_err  = error;
          got_idx  = int'(image_idx);
          return;
        end
      end
      if (v.coinc != 0 && pulses > 0) conv_valid = 1'b1;
      conv_image_calc_fin = 1'b1;
      step();
      conv_valid = 1'b0;
      conv_image_calc_fin = 1'b0;
      low_cnt = 0;
      chk("check_enable", conv_enable, 0);
      chk("check_busy", busy, 1);
      if (!conv_enable) low_cnt++;
      if (img < eff - 1 && v.rdy_delay > 0) out_ready = 1'b0;
      step();
      if (pulses != ROWS) begin
        chk("err_flag", error, 1);
        chk("err_busy", busy, 0);
        chk("err_enable", conv_enable, 0);
        chk("err_idx", image_idx, img);
        got_err = error;
        got_idx = int'(image_idx);
        step();
        chk("err_sticky", error, 1);
        chk("err_no_done", done, 0);
        if (done) got_done = 1;
        return;
      end else if (img == eff - 1) begin
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        chk("done_error", error, 0);
        got_done = done;
        got_err  = error;
        got_idx  = int'(image_idx);
        step();
        chk("done_once", done, 0);
        chk("idle_busy", busy, 0);
      end else begin
        chk("gap_idx", image_idx, img + 1);
        for (int g = 0; g < GAPC; g++) begin
          chk("gap_enable", conv_enable, 0);
          chk("gap_busy", busy, 1);
          if (!conv_enable) low_cnt++;
          step();
        end
      end
    end
  endtask

  vec_t tbl[$];

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    int gd, ge, gi, a, eff;
    vec_t r;
    rst_n = 1'b0;
    start = 1'b0;
    num_images = '0;
    out_ready = 1'b1;
    conv_valid = 1'b0;
    conv_image_calc_fin = 1'b0;
    a = int'($urandom_range(0, (1 << AW) - 1));
    conv_ext_rom_addr = AW'(a);

    // num, bad_img, bad_pulses, rdy_delay, coinc, spam, abort, stall, done, err, idx
    tbl.push_back('{3, -1, 24, 0, 0, 0, -1,  0, 1, 0, 2});
    tbl.push_back('{2,  0, 23, 0, 0, 0, -1,  0, 0, 1, 0});
    tbl.push_back('{1, -1, 24, 0, 1, 0, -1,  0, 1, 0, 0});
    tbl.push_back('{2, -1, 24, 9, 0, 0, -1,  0, 1, 0, 1});
    tbl.push_back('{3, -1, 24, 0, 0, 0,  1,  0, 0, 0, 0});
    tbl.push_back('{1, -1, 24, 0, 0, 0, -1,  0, 1, 0, 0});
    tbl.push_back('{0, -1, 24, 0, 0, 0, -1,  0, 1, 0, 0});
    tbl.push_back('{2, -1, 24, 0, 0, 1, -1,  0, 1, 0, 1});
    tbl.push_back('{2, -1, 24, 1, 1, 0, -1,  0, 1, 0, 1});
    tbl.push_back('{3,  1, 56, 0, 0, 0, -1,  0, 0, 1, 1});
    tbl.push_back('{3,  2,  0, 0, 0, 0, -1,  0, 0, 1, 2});
    tbl.push_back('{2,  0, 25, 0, 1, 0, -1,  0, 0, 1, 0});
`ifdef CONV_SCHED_WATCHDOG_EN
    tbl.push_back('{1, -1, 24, 0, 0, 0, -1, 60, 0, 1, 0});
`else
    tbl.push_back('{1, -1, 24, 0, 0, 0, -1, 60, 1, 0, 0});
`endif
    tbl.push_back('{16, -1, 24, 0, 0, 0, -1, 0, 1, 0, 15});

    step();
    step();
    step();
    chk("reset_enable", conv_enable, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_error", error, 0);
    chk("reset_idx", image_idx, 0);
    #1;
    chk("reset_rom_addr", ext_rom_addr, 64'(a));
    rst_n = 1'b1;
    step();
    chk("idle_busy", busy, 0);

    foreach (tbl[i]) begin
      run_batch(tbl[i], gd, ge, gi);
      chk($sformatf("vec%0d_done", i), 64'(gd), 64'(tbl[i].exp_done));
      chk($sformatf("vec%0d_error", i), 64'(ge), 64'(tbl[i].exp_err));
      chk($sformatf("vec%0d_idx", i), 64'(gi), 64'(tbl[i].exp_idx));
    end

    for (int n = 0; n < 8; n++) begin
      r.num        = int'($urandom_range(0, 5));
      r.bad_img    = int'($urandom_range(0, 5));
      case ($urandom_range(0, 3))
        0: r.bad_pulses = 23;
        1: r.bad_pulses = 25;
        2: r.bad_pulses = 56;
        default: r.bad_pulses = 24;
      endcase
      r.rdy_delay  = int'($urandom_range(0, 3));
      r.coinc      = int'($urandom_range(0, 1));
      r.spam       = int'($urandom_range(0, 1));
      r.abort_img  = -1;
      r.stall      = 0;
      eff = (r.num == 0) ? 1 : r.num;
      if (r.bad_img < eff && r.bad_pulses != ROWS) begin
        r.exp_done = 0;
        r.exp_err  = 1;
        r.exp_idx  = r.bad_img;
      end else begin
        r.exp_done = 1;
        r.exp_err  = 0;
        r.exp_idx  = eff - 1;
      end
      run_batch(r, gd, ge, gi);
      chk($sformatf("rand%0d_done", n), 64'(gd), 64'(r.exp_done));
      chk($sformatf("rand%0d_error", n), 64'(ge), 64'(r.exp_err));
      chk($sformatf("rand%0d_idx", n), 64'(gi), 64'(r.exp_idx));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv_layer_batch_scheduler.md
# conv_layer_batch_scheduler

Sequences the convolution layer over a batch of images. It gates the layer's `enable` and offsets its external-ROM address by a per-image base. It counts and checks the emitted feature rows per image, and pauses between images until the downstream consumer is ready. It sits between the system control/ROM and `conv_layer_top`, and is the only block that drives the layer's `enable`.

## Interface
- `ARRAY_SIZE`, 6, feature rows per channel per image
- `TOTAL_WEIGHT`, 4, output channels per image
- `IMAGE_STRIDE`, 64, ROM words between consecutive image bases
- `MAX_IMAGES`, 16, batch-size upper bound; `IMG_WIDTH = logb2(MAX_IMAGES)+1`
- `GAP_CYCLES`, 2, `enable`-low cycles between images (minimum 1)
- `WDOG_CYCLES`, 4096, watchdog limit (only with the macro)

Ports:
- `clk`  in  1  single clock; all logic on its rising edge
- `rst_n`  in  1  reset; synchronous, active-low
- `start`  in  1  one-cycle pulse; starts a batch; ignored unless IDLE
- `num_images`  in  IMG_WIDTH  batch size; sampled on `start`; 0 is treated as 1
- `out_ready`  in  1  downstream can accept the next image's features
- `conv_valid`  in  1  layer `valid`
- `conv_image_calc_fin`  in  1  layer `image_calc_fin`
- `conv_ext_rom_addr`  in  `EXT_ADDR_WIDTH`  layer local ROM address
- `conv_enable`  out  1  to layer `enable`
- `ext_rom_addr`  out  `EXT_ADDR_WIDTH`  `base + conv_ext_rom_addr`, truncated
- `image_idx`  out  IMG_WIDTH  index of the current image
- `busy`  out  1  high in every state except IDLE/DONE/ERR
- `done`  out  1  one-cycle pulse when the batch completes
- `error`  out  1  sticky; cleared by `start` or reset

## Operation
States: IDLE, GAP, WAIT_RDY, RUN, CHECK, DONE, ERR.

- **IDLE**
  - On `start`: latch `num_images`, set `image_idx=0` and `base=0`.
  - Go to WAIT_RDY.
- **WAIT_RDY**
  - Hold `conv_enable=0`.
  - When `out_ready=1`: go to RUN and clear `row_cnt`.
- **RUN**
  - Hold `conv_enable=1`.
  - Each rising edge of `conv_valid` (current value 1, registered value 0) increments `row_cnt`.
  - `row_cnt` saturates at `ARRAY_SIZE*TOTAL_WEIGHT+1`.
  - On `conv_image_calc_fin=1`: go to CHECK.
- **CHECK** (one cycle, `conv_enable=0`)
  - If `row_cnt != ARRAY_SIZE*TOTAL_WEIGHT`: set `error`, go to ERR.
  - Else if the last image is complete: go to DONE.
  - Else: increment `image_idx`, add `IMAGE_STRIDE` to `base`, go to GAP.
- **GAP**
  - `conv_enable=0` for `GAP_CYCLES` cycles, then go to WAIT_RDY.
  - This gives the layer controller a restart edge.
- **DONE**
  - Pulse `done` for one cycle, then go to IDLE.
- **ERR**
  - `conv_enable=0`. Stay until `start`, which clears `error` and begins a new batch.

Arithmetic and rules:
- `base` width is `EXT_ADDR_WIDTH`; the addition wraps modulo 2^`EXT_ADDR_WIDTH`. No overflow flag.
- A `conv_valid` edge in the same cycle as `conv_image_calc_fin` is counted before the check.
- `start` while busy is ignored.
- `out_ready` is only looked at in WAIT_RDY. A drop during RUN has no effect, because the layer has no stall.

## Timing
Values after reset:
- State IDLE.
- `conv_enable=0`, `busy=0`, `done=0`, `error=0`, `image_idx=0`, `base=0`.
- `ext_rom_addr = conv_ext_rom_addr` (combinational adder from registered `base`).

Latencies:
- `start` to `conv_enable=1`: 2 cycles when `out_ready` is already high (IDLE→WAIT_RDY→RUN).
- `conv_image_calc_fin` to `conv_enable=0`: 1 cycle.
- Inter-image gap: `1 + GAP_CYCLES + 1` cycles minimum.
- Last `conv_image_calc_fin` to `done`: 2 cycles.

Other rules:
- `rst_n=0` mid-batch returns to IDLE on the next edge. No `done`, and `error` is cleared.
- `done` and `busy` are never high together.

## Configuration
- `CONV_SCHED_WATCHDOG_EN` defined:
  - A counter runs in RUN and restarts on every `conv_valid` edge.
  - If it reaches `WDOG_CYCLES`: set `error`, go to ERR.
  - `WDOG_CYCLES` is ignored otherwise.
- Undefined: no counter. RUN waits indefinitely for `conv_image_calc_fin`.

## Structure
- Shared package `conv_layer_pkg`:
  - State enum `sched_state_t`.
  - `logb2` function.
  - Constant `ROWS_PER_IMAGE = ARRAY_SIZE*TOTAL_WEIGHT`, as a package function of the parameters.
- Widths come from the global defines (`EXT_ADDR_WIDTH`).
- One sub-module: `conv_sched_edge_counter`. It holds the `conv_valid` rising-edge detect plus the saturating counter, with a synchronous clear.

## Test plan
- **Nominal batch:** `num_images=3`, `out_ready=1`, 24 valid pulses per image.
  - Expect `image_idx` 0→1→2.
  - Expect base offsets 0, 64, 128 on `ext_rom_addr`.
  - Expect a single `done` 2 cycles after the third fin; `error=0`.
- **Short image:** 23 valid pulses then fin.
  - Expect `error=1` the next cycle, `conv_enable` held 0, no `done`.
  - A following `start` clears `error`.
- **Backpressure:** `out_ready=0` for 10 cycles after image 0.
  - Expect `conv_enable` low for 1+2+10 cycles, then high the cycle after `out_ready` rises.
- **Reset mid-RUN:** `rst_n=0` during image 1.
  - Next cycle expect all outputs at reset values.
  - A new `start` then runs from `image_idx=0`.
- **Edge cases:**
  - `num_images=0` behaves as 1.
  - `start` pulses during RUN are ignored.
  - Valid edge coincident with fin is counted, so 24 passes.
- **Watchdog (macro defined, `WDOG_CYCLES=50`):** no valid for 50 cycles in RUN.
  - Expect `error=1` and state ERR.
  - Without the macro, the same stimulus stays in RUN.
